mc_datapath: RTL and testbench
==============================

# mc_datapath

Parametrised multicycle RV32 datapath: PC, instruction/data registers, register file, immediate extender, ALU and the non-architectural latches (OldPC, IR, Data, A, WriteData, ALUOut), driven state-by-state by the multicycle controller. It generalises datapath width and register count (RV32I/RV32E), adds branch-compare flags, and replaces the fixed single-cycle memory with a request/ready handshake. Stall is reported back to the controller.

## Interface
- XLEN, 32, datapath width (≥32)
- NREGS, 32, architectural registers: 32 (RV32I) or 16 (RV32E)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- PCWrite, IRWrite, RegWrite, AdrSrc, MemAccess, MemWrite  in  1 each  controller strobes
- ResultSrc, ALUSrcA, ALUSrcB  in  2 each  mux selects
- ImmSrc  in  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- Op  out  7  IR[6:0]; Funct3 out 3 IR[14:12]; Funct7b5 out 1 IR[30]
- Zero, Lt, Ltu  out  1 each  ALU flags: result==0, signed SrcA<SrcB, unsigned SrcA<SrcB
- Stall  out  1  memory access outstanding; controller holds state
- BadReg  out  1  decoded rs1/rs2/rd index ≥ NREGS
- mem_req  out  1; mem_we  out  1; mem_addr  out  XLEN; mem_wdata  out  XLEN
- mem_rdata  in  XLEN; mem_ready  in  1
- PC  out  XLEN  current PC

## Operation
- Adr = AdrSrc ? ALUOut : PC. SrcA: 0 PC, 1 OldPC, 2 A, 3 zero. SrcB: 0 WriteData, 1 ImmExt, 2 constant 4, 3 zero. Result: 0 ALUOut, 1 Data, 2 ALUResult, 3 ImmExt.
- Memory FSM, states IDLE, BUSY:
  - IDLE: mem_req = MemAccess; mem_addr/mem_we/mem_wdata driven from Adr/MemWrite/WriteData. MemAccess & !mem_ready → latch addr/we/wdata, go BUSY.
  - BUSY: mem_req=1 from latched values; mem_ready → IDLE.
  - Stall = mem_req & !mem_ready.
- Completion (mem_req & mem_ready): IRWrite → IR←mem_rdata, OldPC←PC; read → Data←mem_rdata.
- PC, IR, OldPC, RegWrite updates gated by !Stall. A, WriteData, ALUOut load every non-stalled cycle.
- Register file: x0 reads 0, writes dropped. Index ≥ NREGS reads 0, write dropped, BadReg=1.
- Shifts use SrcB[4:0]. Arithmetic wraps modulo 2^XLEN. Immediates are sign-extended to XLEN; U-type is imm<<12.

## Timing
- Reset values:
  - PC=RESET_PC.
  - IR, OldPC, Data, A, WriteData, ALUOut and all registers = 0.
  - FSM=IDLE, mem_req=0, Stall=0.
- Zero-wait memory (mem_ready with mem_req): access completes the same cycle, no Stall. N wait states → Stall high N cycles, capture on the (N+1)th edge.
- mem_addr, mem_we, mem_wdata are stable from the first mem_req cycle until the ready cycle. mem_req never drops before ready.
- mem_ready without mem_req is ignored.
- Register file: combinational read; write on clk edge. A read of the register being written in the same cycle returns the old value.
- Reset mid-access: mem_req drops asynchronously. The memory side must tolerate an abandoned request.

## Structure
- Shared package mc_pkg holds:
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings as localparams.
  - FSM state encoding.
- One sub-module, mc_regfile: parameters XLEN and NREGS, 2 read ports and 1 write port, x0/BadReg handling, async active-low reset.
- ALU and extender stay inline.

## Test plan
- Reset release → PC=RESET_PC (try 0x1000), mem_req=0, Stall=0, all latches 0.
- Fetch with mem_ready tied high, mem_rdata=0x00500093 (addi x1,x0,5) → IR updated next edge, OldPC=PC, Op=0x13, no Stall.
- Fetch with 3 wait states → Stall high exactly 3 cycles; mem_addr and mem_req stable throughout; PC and IR unchanged until the ready edge.
- sw then lw at 0x40 of 0xDEADBEEF, 2 wait states each → mem_we=1 and mem_wdata=0xDEADBEEF on the store; Data=0xDEADBEEF after the load; register written via ResultSrc=1.
- Write 7 to x0 → x0 reads 0. With NREGS=16, rd=x20 → BadReg=1, no write; read of x20 returns 0.
- SrcA=0xFFFFFFFF, SrcB=1, sub → Lt=1, Ltu=0, Zero=0. Equal operands → Zero=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32 datapath: controller selects and memory FSM states.
package mc_pkg;

  localparam int unsigned ALUCTL_W = 4;
  localparam int unsigned IMMSRC_W = 3;
  localparam int unsigned SEL_W    = 2;

  localparam logic [ALUCTL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUCTL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUCTL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [ALUCTL_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALUCTL_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [ALUCTL_W-1:0] ALU_SRA  = 4'd9;

  localparam logic [IMMSRC_W-1:0] IMM_I = 3'd0;
  localparam logic [IMMSRC_W-1:0] IMM_S = 3'd1;
  localparam logic [IMMSRC_W-1:0] IMM_B = 3'd2;
  localparam logic [IMMSRC_W-1:0] IMM_J = 3'd3;
  localparam logic [IMMSRC_W-1:0] IMM_U = 3'd4;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'd0;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'd1;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'd2;
  localparam logic [SEL_W-1:0] RES_IMMEXT    = 2'd3;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'd0;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'd1;
  localparam logic [SEL_W-1:0] SRCA_A     = 2'd2;
  localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'd3;

  localparam logic [SEL_W-1:0] SRCB_WD   = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_ZERO = 2'd3;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mc_mem_if.sv
// Request/ready memory port shared by instruction fetch and data access.
interface mc_mem_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_regfile.sv
// Two-read/one-write register file; x0 and indices beyond NREGS read zero and ignore writes.
module mc_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            bad_c
);

  localparam int unsigned IW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic in_range(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  assign rd1   = (ra1 != 5'd0 && in_range(ra1)) ? regs[ra1[IW-1:0]] : '0;
  assign rd2   = (ra2 != 5'd0 && in_range(ra2)) ? regs[ra2[IW-1:0]] : '0;
  assign bad_c = !in_range(ra1) || !in_range(ra2) || !in_range(wa);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[IW'(i)] <= '0;
    end else if (we && wa != 5'd0 && in_range(wa)) begin
      regs[wa[IW-1:0]] <= wd;
    end
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle RV32 datapath: PC, non-architectural latches, ALU, extender and a handshaked memory port.
module mc_datapath import mc_pkg::*; #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PCWrite,
  input  logic                IRWrite,
  input  logic                RegWrite,
  input  logic                AdrSrc,
  input  logic                MemAccess,
  input  logic                MemWrite,
  input  logic [SEL_W-1:0]    ResultSrc,
  input  logic [SEL_W-1:0]    ALUSrcA,
  input  logic [SEL_W-1:0]    ALUSrcB,
  input  logic [IMMSRC_W-1:0] ImmSrc,
  input  logic [ALUCTL_W-1:0] ALUControl,
  output logic [6:0]          Op,
  output logic [2:0]          Funct3,
  output logic                Funct7b5,
  output logic                Zero,
  output logic                Lt,
  output logic                Ltu,
  output logic                Stall,
  output logic                BadReg,
  mc_mem_if.master            mem,
  output logic [XLEN-1:0]     PC
);

  logic [31:0]     ir_q;
  logic [XLEN-1:0] pc_q, oldpc_q, data_q, a_q, wd_q, aluout_q;
  logic [XLEN-1:0] rf_rd1, rf_rd2, src_a, src_b, imm_ext, alu_result, result, adr;
  logic [31:0]     imm32;
  logic [4:0]      shamt;
  logic            lt_c, ltu_c, done_c, stall_c;

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, addr_c, wdata_c;
  logic            we_q, we_c, req_c;

  assign Op       = ir_q[6:0];
  assign Funct3   = ir_q[14:12];
  assign Funct7b5 = ir_q[30];
  assign PC       = pc_q;
  assign adr      = AdrSrc ? aluout_q : pc_q;

  mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .rst_n (reset),
    .we    (RegWrite & ~stall_c),
    .ra1   (ir_q[19:15]),
    .ra2   (ir_q[24:20]),
    .wa    (ir_q[11:7]),
    .wd    (result),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .bad_c (BadReg)
  );

  // Immediate extender: build the 32-bit immediate, then sign-extend to XLEN
  always_comb begin
    imm32 = '0;
    case (ImmSrc)
      IMM_I:   imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      IMM_B:   imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      IMM_J:   imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      IMM_U:   imm32 = {ir_q[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm_ext = XLEN'($signed(imm32));

  always_comb begin
    src_a = '0;
    case (ALUSrcA)
      SRCA_PC:    src_a = pc_q;
      SRCA_OLDPC: src_a = oldpc_q;
      SRCA_A:     src_a = a_q;
      default:    src_a = '0;
    endcase
    src_b = '0;
    case (ALUSrcB)
      SRCB_WD:   src_b = wd_q;
      SRCB_IMM:  src_b = imm_ext;
      SRCB_FOUR: src_b = XLEN'(4);
      default:   src_b = '0;
    endcase
  end

  assign shamt = src_b[4:0];
  assign lt_c  = $signed(src_a) < $signed(src_b);
  assign ltu_c = src_a < src_b;

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, lt_c};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, ltu_c};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);
  assign Lt   = lt_c;
  assign Ltu  = ltu_c;

  always_comb begin
    result = aluout_q;
    case (ResultSrc)
      RES_ALUOUT:    result = aluout_q;
      RES_DATA:      result = data_q;
      RES_ALURESULT: result = alu_result;
      default:       result = imm_ext;
    endcase
  end

  // Memory FSM: IDLE passes requests straight through, BUSY replays the latched request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= MEM_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    addr_c  = adr;
    we_c    = MemWrite;
    wdata_c = wd_q;
    case (state_q)
      MEM_IDLE: begin
        req_c = MemAccess;
        if (MemAccess && !mem.mem_ready) state_d = MEM_BUSY;
      end
      MEM_BUSY: begin
        req_c   = 1'b1;
        addr_c  = addr_q;
        we_c    = we_q;
        wdata_c = wdata_q;
        if (mem.mem_ready) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign stall_c       = req_c & ~mem.mem_ready;
  assign done_c        = req_c & mem.mem_ready;
  assign Stall         = stall_c;
  assign mem.mem_req   = req_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_wdata = wdata_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state_q == MEM_IDLE && MemAccess && !mem.mem_ready) begin
      addr_q  <= adr;
      we_q    <= MemWrite;
      wdata_q <= wd_q;
    end
  end

  // Architectural and non-architectural latches; all hold while the memory stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      oldpc_q  <= '0;
      data_q   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      aluout_q <= '0;
    end else begin
      if (!stall_c) begin
        a_q      <= rf_rd1;
        wd_q     <= rf_rd2;
        aluout_q <= alu_result;
        if (PCWrite) pc_q <= result;
      end
      if (done_c) begin
        if (IRWrite) begin
          ir_q    <= mem.mem_rdata[31:0];
          oldpc_q <= pc_q;
        end
        if (!we_c) data_q <= mem.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench: drives controller strobes by hand and checks the datapath against hand-computed values.
module tb_mc_datapath;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite, IRWrite, RegWrite, AdrSrc, MemAccess, MemWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] rdata;
  logic        ready;

  logic [6:0]  Op, Op16;
  logic [2:0]  Funct3, Funct3_16;
  logic        Funct7b5, Funct7b5_16;
  logic        Zero, Lt, Ltu, Stall, BadReg;
  logic        Zero16, Lt16, Ltu16, Stall16, BadReg16;
  logic [31:0] PC, PC16;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] pc;

  mc_mem_if #(.XLEN(32)) mif ();
  mc_mem_if #(.XLEN(32)) mif16 ();
  assign mif.mem_rdata   = rdata;
  assign mif.mem_ready   = ready;
  assign mif16.mem_rdata = rdata;
  assign mif16.mem_ready = ready;

  always #5 clk = ~clk;

  mc_datapath #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .reset(rst_n),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .MemAccess(MemAccess), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5), .Zero(Zero), .Lt(Lt), .Ltu(Ltu),
    .Stall(Stall), .BadReg(BadReg), .mem(mif.master), .PC(PC)
  );

  mc_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut16 (
    .clk(clk), .reset(rst_n),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .MemAccess(MemAccess), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Op(Op16), .Funct3(Funct3_16), .Funct7b5(Funct7b5_16), .Zero(Zero16), .Lt(Lt16), .Ltu(Ltu16),
    .Stall(Stall16), .BadReg(BadReg16), .mem(mif16.master), .PC(PC16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    PCWrite = 0; IRWrite = 0; RegWrite = 0; AdrSrc = 0; MemAccess = 0; MemWrite = 0;
    ResultSrc = RES_ALUOUT; ALUSrcA = SRCA_PC; ALUSrcB = SRCB_WD; ImmSrc = IMM_I;
    ALUControl = ALU_ADD;
  endtask

  // Fetch at the modelled pc with the given number of wait states, then PC += 4
  task automatic fetch(input logic [31:0] instr, input int waits);
    logic [31:0] old_ir;
    old_ir = dut.ir_q;
    clear();
    MemAccess = 1; IRWrite = 1; PCWrite = 1;
    ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ALUControl = ALU_ADD; ResultSrc = RES_ALURESULT;
    rdata = instr;
    for (int i = 0; i < waits; i++) begin
      ready = 0;
      #1;
      check("fetch_stall", 32'(Stall), 32'd1);
      check("fetch_req", 32'(mif.mem_req), 32'd1);
      check("fetch_addr", mif.mem_addr, pc);
      check("fetch_pc_hold", PC, pc);
      check("fetch_ir_hold", dut.ir_q, old_ir);
      tick();
    end
    ready = 1;
    #1;
    check("fetch_ready_nostall", 32'(Stall), 32'd0);
    check("fetch_ready_addr", mif.mem_addr, pc);
    tick();
    check("fetch_ir", dut.ir_q, instr);
    check("fetch_oldpc", dut.oldpc_q, pc);
    pc = pc + 32'd4;
    check("fetch_pc", PC, pc);
    clear();
    ready = 0;
  endtask

  task automatic mem_access(input logic we, input int waits, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd);
    clear();
    AdrSrc = 1; MemAccess = 1; MemWrite = we; rdata = rd;
    for (int i = 0; i < waits; i++) begin
      ready = 0;
      #1;
      check("mem_stall", 32'(Stall), 32'd1);
      check("mem_req", 32'(mif.mem_req), 32'd1);
      check("mem_addr", mif.mem_addr, addr);
      check("mem_we", 32'(mif.mem_we), 32'(we));
      if (we) check("mem_wdata", mif.mem_wdata, wdata);
      tick();
    end
    ready = 1;
    #1;
    check("mem_ready_addr", mif.mem_addr, addr);
    check("mem_ready_nostall", 32'(Stall), 32'd0);
    tick();
    clear();
    ready = 0;
  endtask

  task automatic exec_imm(input logic [2:0] isrc);
    clear();
    ALUSrcA = SRCA_A; ALUSrcB = SRCB_IMM; ImmSrc = isrc; ALUControl = ALU_ADD;
    tick();
  endtask

  task automatic writeback(input logic [1:0] rsrc, input logic [2:0] isrc);
    clear();
    RegWrite = 1; ResultSrc = rsrc; ImmSrc = isrc;
    tick();
    clear();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  ops  [10];
    logic [31:0] exps [10];
    ops  = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA};
    exps = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
             32'h1, 32'h0, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

    rst_n = 0; ready = 0; rdata = '0;
    clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", PC, 32'h0000_1000);
    check("rst_req", 32'(mif.mem_req), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_ir", dut.ir_q, 32'd0);
    check("rst_oldpc", dut.oldpc_q, 32'd0);
    check("rst_data", dut.data_q, 32'd0);
    check("rst_a", dut.a_q, 32'd0);
    check("rst_wd", dut.wd_q, 32'd0);
    check("rst_aluout", dut.aluout_q, 32'd0);
    rst_n = 1;
    pc = 32'h0000_1000;
    tick();

    // addi x1,x0,5 with zero-wait fetch
    fetch(32'h0050_0093, 0);
    check("addi_op", 32'(Op), 32'h13);
    check("addi_f3", 32'(Funct3), 32'd0);
    clear(); tick();
    exec_imm(IMM_I);
    check("addi_aluout", dut.aluout_q, 32'd5);
    writeback(RES_ALUOUT, IMM_I);
    check("addi_x1", dut.u_regfile.regs[1], 32'd5);

    // mem_ready without a request must not load IR
    clear(); IRWrite = 1; ready = 1; rdata = 32'hFFFF_FFFF;
    #1;
    check("noreq_req", 32'(mif.mem_req), 32'd0);
    tick();
    check("noreq_ir", dut.ir_q, 32'h0050_0093);
    ready = 0; clear();

    // lui x2,0xDEADC with three wait states
    fetch(32'hDEAD_C137, 3);
    check("lui_op", 32'(Op), 32'h37);
    writeback(RES_IMMEXT, IMM_U);
    check("lui_x2", dut.u_regfile.regs[2], 32'hDEAD_C000);

    // addi x2,x2,-0x111
    fetch(32'hEEF1_0113, 0);
    clear(); tick();
    exec_imm(IMM_I);
    writeback(RES_ALUOUT, IMM_I);
    check("addi_x2", dut.u_regfile.regs[2], 32'hDEAD_BEEF);

    // sw x2,0x40(x0), two wait states
    fetch(32'h0420_2023, 0);
    clear(); tick();
    exec_imm(IMM_S);
    check("sw_aluout", dut.aluout_q, 32'h40);
    mem_access(1'b1, 2, 32'h40, 32'hDEAD_BEEF, 32'h0);

    // lw x3,0x40(x0), two wait states
    fetch(32'h0400_2183, 0);
    clear(); tick();
    exec_imm(IMM_I);
    mem_access(1'b0, 2, 32'h40, 32'h0, 32'hDEAD_BEEF);
    check("lw_data", dut.data_q, 32'hDEAD_BEEF);
    writeback(RES_DATA, IMM_I);
    check("lw_x3", dut.u_regfile.regs[3], 32'hDEAD_BEEF);

    // addi x0,x0,7: write to x0 dropped
    fetch(32'h0070_0013, 0);
    writeback(RES_IMMEXT, IMM_I);
    check("x0_read", dut.rf_rd1, 32'd0);
    check("x0_store", dut.u_regfile.regs[0], 32'd0);

    // addi x20,x20,7: out of range only on the 16-register instance
    fetch(32'h007A_0A13, 0);
    check("bad16", 32'(BadReg16), 32'd1);
    check("bad32", 32'(BadReg), 32'd0);
    writeback(RES_IMMEXT, IMM_I);
    check("x20_write32", dut.u_regfile.regs[20], 32'd7);
    check("x20_alias16", dut16.u_regfile.regs[4], 32'd0);
    check("x20_read16", dut16.rf_rd1, 32'd0);

    // x5 = -1, then A = x5 via addi x6,x5,1
    fetch(32'hFFF0_0293, 0);
    writeback(RES_IMMEXT, IMM_I);
    fetch(32'h0012_8313, 0);
    clear(); tick();
    check("a_minus1", dut.a_q, 32'hFFFF_FFFF);
    clear(); ALUSrcA = SRCA_A; ALUSrcB = SRCB_IMM; ImmSrc = IMM_I;
    for (int i = 0; i < 10; i++) begin
      ALUControl = ops[i];
      #1;
      check("alu_op", dut.alu_result, exps[i]);
    end
    ALUControl = ALU_SUB;
    #1;
    check("sub_zero", 32'(Zero), 32'd0);
    check("sub_lt", 32'(Lt), 32'd1);
    check("sub_ltu", 32'(Ltu), 32'd0);
    ALUSrcA = SRCA_ZERO; ALUSrcB = SRCB_ZERO;
    #1;
    check("eq_zero", 32'(Zero), 32'd1);
    check("eq_lt", 32'(Lt), 32'd0);
    tick();

    // Reset while a fetch is waiting
    clear(); MemAccess = 1; ready = 0;
    tick();
    check("abandon_req_before", 32'(mif.mem_req), 32'd1);
    rst_n = 0; MemAccess = 0;
    #1;
    check("abandon_req", 32'(mif.mem_req), 32'd0);
    check("abandon_stall", 32'(Stall), 32'd0);
    check("abandon_pc", PC, 32'h0000_1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
